// File: rtl/ddr2_st_adapter_pkg.sv
// ----------------------------------------------------------------------------
// ddr2_st_adapter_pkg
// Shared types and constants for the DDR2 controller streaming channel
// adapter: packet-tracking FSM state encoding, drop counter width and a
// saturating increment helper.
// ----------------------------------------------------------------------------
package ddr2_st_adapter_pkg;

  localparam int DROP_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IN_PKT = 2'd1,
    DROP   = 2'd2
  } adapter_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
    return (&value) ? value : value + DROP_CNT_W'(1);
  endfunction

endpackage

// File: rtl/ddr2_controller_st_skid_buf.sv
// ----------------------------------------------------------------------------
// ddr2_controller_st_skid_buf
// Two-entry registered skid buffer for a valid/ready stream. The output
// register gives one cycle of latency; the skid register absorbs the beat
// accepted in the cycle the sink stalls, so full throughput is kept while
// in_ready comes straight from a flop. in_ready is low only when both
// entries are occupied.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid / in_ready   upstream handshake
//   in_payload            upstream payload (PAYLOAD_W bits)
//   out_valid / out_ready downstream handshake
//   out_payload           registered downstream payload
// ----------------------------------------------------------------------------
module ddr2_controller_st_skid_buf #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload
);

  logic                 out_valid_q,   out_valid_d;
  logic [PAYLOAD_W-1:0] out_payload_q, out_payload_d;
  logic                 skid_valid_q,  skid_valid_d;
  logic [PAYLOAD_W-1:0] skid_payload_q, skid_payload_d;
  logic                 in_ready_q,    in_ready_d;
  logic                 push;

  assign push = in_valid & in_ready_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    out_valid_d    = out_valid_q;
    out_payload_d  = out_payload_q;
    skid_valid_d   = skid_valid_q;
    skid_payload_d = skid_payload_q;

    if (!out_valid_q || out_ready) begin
      // Output slot is free (or being emptied this cycle): refill it,
      // oldest entry first. A held skid entry implies in_ready was low,
      // so push and skid_valid_q are never both set here.
      if (skid_valid_q) begin
        out_payload_d = skid_payload_q;
        out_valid_d   = 1'b1;
        skid_valid_d  = 1'b0;
      end else if (push) begin
        out_payload_d = in_payload;
        out_valid_d   = 1'b1;
      end else begin
        out_valid_d   = 1'b0;
      end
    end else if (push) begin
      // Sink stalled while a beat was accepted: park it in the skid slot.
      skid_payload_d = in_payload;
      skid_valid_d   = 1'b1;
    end

    in_ready_d = !skid_valid_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q    <= 1'b0;
      out_payload_q  <= '0;
      skid_valid_q   <= 1'b0;
      // NOTE: the payload storage is reset as well so that out_data and
      // out_channel read zero during reset and no stale beat survives it.
      skid_payload_q <= '0;
      in_ready_q     <= 1'b0;
    end else begin
      out_valid_q    <= out_valid_d;
      out_payload_q  <= out_payload_d;
      skid_valid_q   <= skid_valid_d;
      skid_payload_q <= skid_payload_d;
      in_ready_q     <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_payload = out_payload_q;

endmodule

// File: rtl/ddr2_controller_st_channel_adapter.sv
// ----------------------------------------------------------------------------
// ddr2_controller_st_channel_adapter
// Streaming channel adapter. Tracks packets with an IDLE/IN_PKT/DROP FSM,
// latches the channel on each SOP, forwards packets whose channel is at
// most MAX_CHANNEL with the channel zero-extended to OUT_CHAN_W, and
// silently accepts and discards everything else while counting the dropped
// beats. The output passes through a 2-entry skid buffer.
//
// Optional feature: define DDR2_ST_CHAN_ADAPTER_PROTOCOL_CHECK_EN to add a
// sticky proto_err output flagging SOP inside a packet and non-SOP beats
// outside a packet.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   in_valid/in_ready            input handshake
//   in_data, in_startofpacket,
//   in_endofpacket, in_channel   input beat (channel taken on SOP only)
//   out_valid/out_ready          output handshake
//   out_data, out_startofpacket,
//   out_endofpacket, out_channel output beat
//   drop_count                   saturating count of discarded beats
//   proto_err                    (optional) sticky protocol violation flag
// ----------------------------------------------------------------------------
module ddr2_controller_st_channel_adapter
  import ddr2_st_adapter_pkg::*;
#(
  parameter int          DATA_W      = 8,
  parameter int          IN_CHAN_W   = 1,
  parameter int          OUT_CHAN_W  = 8,
  parameter int unsigned MAX_CHANNEL = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic [IN_CHAN_W-1:0]  in_channel,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [OUT_CHAN_W-1:0] out_channel,
  output logic [DROP_CNT_W-1:0] drop_count
`ifdef DDR2_ST_CHAN_ADAPTER_PROTOCOL_CHECK_EN
  ,
  output logic                  proto_err
`endif
);

  // Payload layout through the skid buffer: {sop, eop, channel, data}.
  localparam int PAYLOAD_W = DATA_W + OUT_CHAN_W + 2;

  adapter_state_e            state_q, state_d;
  logic [IN_CHAN_W-1:0]      chan_q;
  logic [DROP_CNT_W-1:0]     drop_cnt_q;
  logic                      accept;
  logic                      chan_ok;
  logic                      fwd;
  logic                      drop;
  logic                      latch_chan;
  logic [IN_CHAN_W-1:0]      beat_chan;
  logic                      buf_in_ready;
  logic [PAYLOAD_W-1:0]      buf_in_payload;
  logic [PAYLOAD_W-1:0]      buf_out_payload;

  assign in_ready = buf_in_ready;
  assign accept   = in_valid & buf_in_ready;
  assign chan_ok  = (32'(in_channel) <= MAX_CHANNEL);

  // Next state and per-beat decision. An SOP is always evaluated as if the
  // FSM were in IDLE, whatever state the previous packet left it in.
  always_comb begin
    state_d    = state_q;
    fwd        = 1'b0;
    drop       = 1'b0;
    latch_chan = 1'b0;

    if (accept) begin
      if (in_startofpacket) begin
        if (chan_ok) begin
          fwd        = 1'b1;
          latch_chan = 1'b1;
          state_d    = in_endofpacket ? IDLE : IN_PKT;
        end else begin
          drop    = 1'b1;
          state_d = in_endofpacket ? IDLE : DROP;
        end
      end else begin
        unique case (state_q)
          IN_PKT: begin
            fwd     = 1'b1;
            state_d = in_endofpacket ? IDLE : IN_PKT;
          end
          DROP: begin
            drop    = 1'b1;
            state_d = in_endofpacket ? IDLE : DROP;
          end
          default: begin
            drop    = 1'b1;
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      chan_q     <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_chan) chan_q <= in_channel;
      if (drop) drop_cnt_q <= sat_inc(drop_cnt_q);
    end
  end

  assign drop_count = drop_cnt_q;

  // The SOP beat carries the channel being latched this very edge.
  assign beat_chan      = in_startofpacket ? in_channel : chan_q;
  assign buf_in_payload = {in_startofpacket, in_endofpacket,
                           OUT_CHAN_W'(beat_chan), in_data};

  ddr2_controller_st_skid_buf #(
    .PAYLOAD_W (PAYLOAD_W)
  ) u_skid_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid & fwd),
    .in_ready    (buf_in_ready),
    .in_payload  (buf_in_payload),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (buf_out_payload)
  );

  assign out_startofpacket = buf_out_payload[PAYLOAD_W-1];
  assign out_endofpacket   = buf_out_payload[PAYLOAD_W-2];
  assign out_channel       = buf_out_payload[DATA_W +: OUT_CHAN_W];
  assign out_data          = buf_out_payload[DATA_W-1:0];

`ifdef DDR2_ST_CHAN_ADAPTER_PROTOCOL_CHECK_EN
  logic proto_viol;
  logic proto_err_q;

  assign proto_viol = accept &&
                      (( in_startofpacket && (state_q != IDLE)) ||
                       (!in_startofpacket && (state_q == IDLE)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)        proto_err_q <= 1'b0;
    else if (proto_viol) proto_err_q <= 1'b1;
  end

  assign proto_err = proto_err_q;
`endif

endmodule

// File: tb/tb_ddr2_controller_st_channel_adapter.sv
// ----------------------------------------------------------------------------
// tb_ddr2_controller_st_channel_adapter
// Self-checking bench: a reference packet model pushes expected beats into a
// scoreboard queue as input beats are accepted; a monitor pops and compares
// on every output handshake and checks output stability while stalled.
// ----------------------------------------------------------------------------
module tb_ddr2_controller_st_channel_adapter;

  localparam int DATA_W      = 8;
  localparam int IN_CHAN_W   = 2;
  localparam int OUT_CHAN_W  = 8;
  localparam int MAX_CHANNEL = 1;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  in_ready;
  logic                  in_valid;
  logic [DATA_W-1:0]     in_data;
  logic                  in_startofpacket;
  logic                  in_endofpacket;
  logic [IN_CHAN_W-1:0]  in_channel;
  logic                  out_ready;
  logic                  out_valid;
  logic [DATA_W-1:0]     out_data;
  logic                  out_startofpacket;
  logic                  out_endofpacket;
  logic [OUT_CHAN_W-1:0] out_channel;
  logic [15:0]           drop_count;
`ifdef DDR2_ST_CHAN_ADAPTER_PROTOCOL_CHECK_EN
  logic                  proto_err;
`endif

  ddr2_controller_st_channel_adapter #(
    .DATA_W      (DATA_W),
    .IN_CHAN_W   (IN_CHAN_W),
    .OUT_CHAN_W  (OUT_CHAN_W),
    .MAX_CHANNEL (MAX_CHANNEL)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_channel        (in_channel),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_channel       (out_channel),
    .drop_count        (drop_count)
`ifdef DDR2_ST_CHAN_ADAPTER_PROTOCOL_CHECK_EN
    ,
    .proto_err         (proto_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sop;
    logic       eop;
    logic [7:0] chan;
    logic [7:0] data;
  } beat_t;

  typedef enum int {M_IDLE, M_PKT, M_DROP} model_state_e;

  beat_t        sb_q[$];
  model_state_e m_state = M_IDLE;
  logic [7:0]   m_chan  = '0;
  int           m_drops = 0;
  bit           m_proto = 1'b0;
  int           n_tests = 0;
  int           n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_state = M_IDLE;
    m_chan  = '0;
    m_drops = 0;
    m_proto = 1'b0;
  endtask

  task automatic model_drop();
    if (m_drops < 16'hFFFF) m_drops++;
  endtask

  // Reference behaviour for one accepted input beat.
  task automatic model_accept(input logic [7:0] d, input bit sop, input bit eop,
                              input logic [IN_CHAN_W-1:0] ch);
    beat_t e;
    if (sop) begin
      if (m_state != M_IDLE) m_proto = 1'b1;
      if (int'(ch) <= MAX_CHANNEL) begin
        m_chan = 8'(ch);
        e = '{sop: 1'b1, eop: eop, chan: m_chan, data: d};
        sb_q.push_back(e);
        m_state = eop ? M_IDLE : M_PKT;
      end else begin
        model_drop();
        m_state = eop ? M_IDLE : M_DROP;
      end
    end else if (m_state == M_PKT) begin
      e = '{sop: 1'b0, eop: eop, chan: m_chan, data: d};
      sb_q.push_back(e);
      if (eop) m_state = M_IDLE;
    end else if (m_state == M_DROP) begin
      model_drop();
      if (eop) m_state = M_IDLE;
    end else begin
      m_proto = 1'b1;
      model_drop();
    end
  endtask

  // Presents a beat and holds it until accepted (bounded). Returns #1 after
  // the accepting edge with in_valid still high.
  task automatic send_beat(input logic [7:0] d, input bit sop, input bit eop,
                           input logic [IN_CHAN_W-1:0] ch);
    bit acc = 1'b0;
    in_valid         = 1'b1;
    in_data          = d;
    in_startofpacket = sop;
    in_endofpacket   = eop;
    in_channel       = ch;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (acc) model_accept(d, sop, eop, ch);
    else     check("accept_timeout", 64'(acc), 64'd1);
  endtask

  task automatic idle_in();
    in_valid         = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket   = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_left", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_drop_count"}, 64'(drop_count), 64'(m_drops));
`ifdef DDR2_ST_CHAN_ADAPTER_PROTOCOL_CHECK_EN
    check({tag, "_proto_err"}, 64'(proto_err), 64'(m_proto));
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_out_sop"}, 64'(out_startofpacket), 64'd0);
    check({tag, "_out_eop"}, 64'(out_endofpacket), 64'd0);
    check({tag, "_out_channel"}, 64'(out_channel), 64'd0);
    check({tag, "_drop_count"}, 64'(drop_count), 64'd0);
    check({tag, "_in_ready"}, 64'(in_ready), 64'd0);
`ifdef DDR2_ST_CHAN_ADAPTER_PROTOCOL_CHECK_EN
    check({tag, "_proto_err"}, 64'(proto_err), 64'd0);
`endif
  endtask

  // Output monitor: compares every handshake against the scoreboard and
  // requires the output to hold while stalled.
  bit          stall_prev = 1'b0;
  logic [18:0] hold_val   = '0;

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (stall_prev)
        check("stall_hold",
              64'({out_valid, out_startofpacket, out_endofpacket, out_channel, out_data}),
              64'(hold_val));
      if (out_valid && out_ready) begin
        check("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
        if (sb_q.size() != 0) begin
          beat_t e;
          e = sb_q.pop_front();
          check("out_beat",
                64'({out_startofpacket, out_endofpacket, out_channel, out_data}),
                64'(e));
        end
      end
      stall_prev = out_valid && !out_ready;
      hold_val   = {out_valid, out_startofpacket, out_endofpacket, out_channel, out_data};
    end else begin
      stall_prev = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    in_channel = '0;
    idle_in();

    // Reset state and in_ready release timing.
    #2;
    check_reset_outputs("rst0");
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1 check("rel_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 check("rel_in_ready_high", 64'(in_ready), 64'd1);

    // 4-beat packet on channel 1 (== MAX_CHANNEL), one cycle latency.
    send_beat(8'h11, 1'b1, 1'b0, 2'd1);
    check("s1_lat_valid", 64'(out_valid), 64'd1);
    check("s1_lat_data", 64'(out_data), 64'h11);
    check("s1_lat_chan", 64'(out_channel), 64'h01);
    send_beat(8'h22, 1'b0, 1'b0, 2'd0);
    send_beat(8'h33, 1'b0, 1'b0, 2'd0);
    send_beat(8'h44, 1'b0, 1'b1, 2'd0);
    idle_in();
    drain();
    check_counters("s1");
    check("s1_drop_zero", 64'(drop_count), 64'd0);

    // Streaming packet with a 5-cycle downstream stall.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send_beat(8'(8'h50 + i), i == 0, i == 5, 2'd0);
        idle_in();
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        check("s2_in_ready_low", 64'(in_ready), 64'd0);
        check("s2_out_valid", 64'(out_valid), 64'd1);
        check("s2_hold_data", 64'(out_data), 64'h50);
        check("s2_hold_sop", 64'(out_startofpacket), 64'd1);
        out_ready = 1'b1;
      end
    join
    drain();
    check_counters("s2");

    // Out-of-range channels are dropped; next packet forwarded.
    send_beat(8'h61, 1'b1, 1'b0, 2'd3);
    send_beat(8'h62, 1'b0, 1'b0, 2'd0);
    send_beat(8'h63, 1'b0, 1'b1, 2'd0);
    idle_in();
    repeat (3) @(posedge clk);
    #1;
    check("s3_no_out", 64'(out_valid), 64'd0);
    check("s3_drops", 64'(drop_count), 64'd3);
    send_beat(8'h64, 1'b1, 1'b1, 2'd2);
    send_beat(8'h71, 1'b1, 1'b0, 2'd0);
    send_beat(8'h72, 1'b0, 1'b1, 2'd0);
    idle_in();
    drain();
    check_counters("s3");

    // Single-beat packet immediately followed by another packet.
    send_beat(8'hA5, 1'b1, 1'b1, 2'd1);
    send_beat(8'hB1, 1'b1, 1'b0, 2'd0);
    send_beat(8'hB2, 1'b0, 1'b1, 2'd0);
    idle_in();
    drain();
    check_counters("s4");

    // SOP inside a packet restarts on the new channel.
    send_beat(8'h81, 1'b1, 1'b0, 2'd0);
    send_beat(8'h82, 1'b0, 1'b0, 2'd0);
    send_beat(8'h83, 1'b1, 1'b0, 2'd1);
    send_beat(8'h84, 1'b0, 1'b1, 2'd0);
    idle_in();
    drain();
    check_counters("s5");
`ifdef DDR2_ST_CHAN_ADAPTER_PROTOCOL_CHECK_EN
    check("s5_proto_set", 64'(proto_err), 64'd1);
    repeat (5) @(posedge clk);
    #1 check("s5_proto_sticky", 64'(proto_err), 64'd1);
`endif

    // Non-SOP beat while idle is dropped.
    send_beat(8'h91, 1'b0, 1'b0, 2'd0);
    idle_in();
    drain();
    check_counters("s5b");

    // Asynchronous reset in the middle of a packet.
    send_beat(8'hC1, 1'b1, 1'b0, 2'd1);
    send_beat(8'hC2, 1'b0, 1'b0, 2'd0);
    idle_in();
    check("s6_pre_valid", 64'(out_valid), 64'd1);
    #3 reset_n = 1'b0;
    #1;
    check_reset_outputs("s6_rst");
    model_reset();
    @(posedge clk);
    #3 reset_n = 1'b1;
    #1 check("s6_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 check("s6_in_ready_high", 64'(in_ready), 64'd1);
    send_beat(8'hD1, 1'b1, 1'b0, 2'd1);
    send_beat(8'hD2, 1'b0, 1'b1, 2'd0);
    idle_in();
    drain();
    check_counters("s6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr2_controller_st_channel_adapter.md
DDR2_CONTROLLER_ST_CHANNEL_ADAPTER -- requirements
Module: ddr2_controller_st_channel_adapter

Interface
REQ-001 Parameter DATA_W, default 8: data bus width in bits, 8..64.
REQ-002 Parameter IN_CHAN_W, default 1: input channel width in bits, 1..8.
REQ-003 Parameter OUT_CHAN_W, default 8: output channel width in bits, at least IN_CHAN_W.
REQ-004 Parameter MAX_CHANNEL, default 1: highest legal channel number.
REQ-005 Ports (name, direction, width, meaning):
 - clk, in, 1, sole clock.
 - reset_n, in, 1, asynchronous active-low reset.
 - in_ready, out, 1, sink ready.
 - in_valid, in, 1, beat valid.
 - in_data, in, DATA_W, payload.
 - in_startofpacket, in, 1, SOP.
 - in_endofpacket, in, 1, EOP.
 - in_channel, in, IN_CHAN_W, channel, sampled on the SOP beat only.
 - out_ready, in, 1, downstream ready.
 - out_valid, out, 1, beat valid.
 - out_data, out, DATA_W, payload.
 - out_startofpacket, out, 1, SOP.
 - out_endofpacket, out, 1, EOP.
 - out_channel, out, OUT_CHAN_W, zero-extended latched channel.
 - drop_count, out, 16, saturating count of dropped beats.

Function
REQ-006 The adapter SHALL accept an input beat when in_valid and in_ready are both 1, and SHALL emit an output beat when out_valid and out_ready are both 1.
REQ-007 Output SHALL be registered through a 2-entry skid buffer: 1-cycle latency, full throughput, in_ready SHALL be driven directly from a flop and SHALL be 0 only when the buffer holds 2 entries.
REQ-008 FSM states: IDLE, IN_PKT, DROP.
 - IDLE: a beat without SOP SHALL be dropped.
 - IDLE: SOP with channel <= MAX_CHANNEL SHALL latch the channel, forward the beat, and go to IN_PKT, or stay in IDLE if EOP is on the same beat.
 - IDLE: SOP with channel > MAX_CHANNEL SHALL drop the beat and go to DROP, or stay in IDLE if EOP is on the same beat.
REQ-009 IN_PKT: each beat SHALL be forwarded with the latched channel; an EOP beat SHALL return the FSM to IDLE.
REQ-010 DROP: each beat SHALL be discarded; an EOP beat SHALL return the FSM to IDLE.
REQ-011 An SOP beat received in IN_PKT or DROP SHALL be handled as a fresh SOP from IDLE (the channel is re-evaluated); the preceding packet is left unterminated.
REQ-012 out_channel SHALL equal the latched channel zero-extended to OUT_CHAN_W and SHALL be constant for every beat of a packet.
REQ-013 Each dropped beat SHALL increment drop_count by 1, saturating at 16'hFFFF.
REQ-014 Dropped beats SHALL still be accepted, so in_ready is unaffected by dropping.
REQ-015 out_valid, out_startofpacket and out_endofpacket SHALL NOT change while out_valid=1 and out_ready=0.

Reset
REQ-016 Asserting reset_n low SHALL immediately force the following, regardless of clk:
 - FSM to IDLE and skid buffer empty.
 - out_valid=0, out_data=0, out_startofpacket=0, out_endofpacket=0, out_channel=0.
 - drop_count=0 and in_ready=0.
REQ-017 in_ready SHALL rise on the first clk edge after reset_n deasserts.
REQ-018 A packet in flight when reset is asserted SHALL be discarded.

Configuration
REQ-019 When macro DDR2_ST_CHAN_ADAPTER_PROTOCOL_CHECK_EN is defined, the block SHALL add output port proto_err (1 bit, sticky, cleared only by reset).
REQ-020 proto_err SHALL be set by:
 - an SOP while in IN_PKT or DROP;
 - a non-SOP beat while in IDLE.
REQ-021 Without DDR2_ST_CHAN_ADAPTER_PROTOCOL_CHECK_EN the proto_err port and its logic SHALL be absent, and all other behaviour is identical.

Structure
REQ-022 Package ddr2_st_adapter_pkg SHALL hold the FSM state enum typedef (IDLE, IN_PKT, DROP) and the constant DROP_CNT_W=16.
REQ-023 The skid buffer SHALL be the sub-module ddr2_controller_st_skid_buf, parametrised on payload width, and the top level SHALL contain the FSM, channel latch and counter.

Verification
REQ-024 The bench SHALL cover the following directed scenarios (defaults DATA_W=8, IN_CHAN_W=1, MAX_CHANNEL=1 unless stated):
 - 4-beat packet, channel 1, 0x11..0x44, out_ready=1: 4 out beats 1 cycle later, out_channel=8'h01 on all beats, SOP on first, EOP on last, drop_count=0.
 - out_ready held 0 for 5 cycles during a streaming packet: in_ready=0 after 2 beats buffered, no beat lost or duplicated, output stable while stalled.
 - IN_CHAN_W=2, MAX_CHANNEL=1, SOP on channel 3 in a 3-beat packet: no out beats, drop_count=3, FSM back in IDLE; next packet on channel 0 is forwarded.
 - Single-beat packet (SOP and EOP together, data 0xA5) followed by a packet the next cycle: both forwarded, with correct SOP/EOP per beat.
 - SOP arrives mid-packet with the macro defined: proto_err=1, new channel latched, proto_err stays 1 until reset.
 - reset_n pulsed low mid-packet: all outputs go to 0 asynchronously, drop_count=0, and the next SOP is forwarded normally.
